hamming_secded_decoder: RTL and testbench

- Program-2 datapath block. It is the receive side of the (16,11) SECDED Hamming code that program 1 produces.
- It walks data memory, reads NUM_WORDS encoded 16-bit words, corrects single-bit errors, flags double-bit errors, and writes the recovered 11-bit data plus a 2-bit status back to memory.
- Sits beside dm1 and arbitrates no one. It owns the data-memory port while busy.

---
 rtl/hamming_secded_decoder.sv | 168 ++++++++++++++++
 tb/tb_hamming_secded_decoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_decoder.sv
// Receive side of the (16,11) SECDED Hamming code: reads encoded words from data
// memory, corrects single errors, flags double errors, writes data plus status back.
module hamming_secded_decoder #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic [4:0]    corr_cnt,
  output logic [4:0]    dbl_cnt,
  output logic          done,
  output logic [2:0]    dbg_state
);

  localparam int            IW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_LO  = 3'd1,
    S_RD_HI  = 3'd2,
    S_CAP_HI = 3'd3,
    S_DECODE = 3'd4,
    S_WR_LO  = 3'd5,
    S_WR_HI  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_lo;
  logic [15:0]   r_word;
  logic [10:0]   r_data;
  logic [1:0]    r_flag;
  logic [4:0]    r_corr;
  logic [4:0]    r_dbl;
  logic          r_done;

  logic [3:0]    w_syn;
  logic          w_par;
  logic [10:0]   w_dmask;
  logic [10:0]   w_data;
  logic [1:0]    w_flag;
  logic          w_last;
  logic [AW-1:0] w_src_addr;
  logic [AW-1:0] w_dst_addr;

  assign w_last     = (r_idx == LAST_IDX);
  assign w_src_addr = AW'(SRC_BASE) + AW'({r_idx, 1'b0});
  assign w_dst_addr = AW'(DST_BASE) + AW'({r_idx, 1'b0});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // start is a single-cycle pulse; it is only looked at in IDLE and DONE
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nx = S_RD_LO;
      S_RD_LO:        w_state_nx = S_RD_HI;
      S_RD_HI:        w_state_nx = S_CAP_HI;
      S_CAP_HI:       w_state_nx = S_DECODE;
      S_DECODE:       w_state_nx = S_WR_LO;
      S_WR_LO:        w_state_nx = S_WR_HI;
      S_WR_HI:        w_state_nx = w_last ? S_DONE : S_RD_LO;
      default:        w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (r_state)
      S_RD_LO: mem_addr = w_src_addr;
      S_RD_HI: mem_addr = w_src_addr + AW'(1);
      S_WR_LO: begin
        mem_addr    = w_dst_addr;
        mem_wr_en   = 1'b1;
        mem_wr_data = r_data[7:0];
      end
      S_WR_HI: begin
        mem_addr    = w_dst_addr + AW'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = {r_flag, 3'b000, r_data[10:8]};
      end
      default: ;
    endcase
  end

  // Syndrome is the XOR of the positions of all set bits 1..15
  always_comb begin
    w_syn = '0;
    for (int j = 1; j < 16; j++) begin
      if (r_word[j]) w_syn = w_syn ^ 4'(j);
    end
  end

  assign w_par = ^r_word;

  // Parity positions (0,1,2,4,8) map to no data bit, so their mask stays zero
  always_comb begin
    w_dmask = '0;
    case (w_syn)
      4'd3:  w_dmask = 11'h001;
      4'd5:  w_dmask = 11'h002;
      4'd6:  w_dmask = 11'h004;
      4'd7:  w_dmask = 11'h008;
      4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15:
             w_dmask = 11'h010 << (w_syn - 4'd9);
      default: w_dmask = '0;
    endcase
    w_flag = 2'b00;
    if (w_par)              w_flag = 2'b01;
    else if (w_syn != 4'd0) w_flag = 2'b10;
    w_data = {r_word[15:9], r_word[7:5], r_word[3]} ^ (w_par ? w_dmask : 11'h000);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx  <= '0;
      r_lo   <= '0;
      r_word <= '0;
      r_data <= '0;
      r_flag <= '0;
      r_corr <= '0;
      r_dbl  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE) && (w_state_nx == S_DONE);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_idx  <= '0;
            r_corr <= '0;
            r_dbl  <= '0;
          end
        end
        S_RD_HI:  r_lo   <= mem_rd_data;
        S_CAP_HI: r_word <= {mem_rd_data, r_lo};
        S_DECODE: begin
          r_data <= w_data;
          r_flag <= w_flag;
          if (w_flag == 2'b01 && r_corr != 5'd31) r_corr <= r_corr + 5'd1;
          if (w_flag == 2'b10 && r_dbl  != 5'd31) r_dbl  <= r_dbl + 5'd1;
        end
        S_WR_HI: if (!w_last) r_idx <= r_idx + IW'(1);
        default: ;
      endcase
    end
  end

  assign corr_cnt  = r_corr;
  assign dbl_cnt   = r_dbl;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: memory model, reference encoder/decoder,
// directed and randomized runs, timing, restart and mid-run reset scenarios.
module tb_hamming_secded_decoder;

  localparam int NW  = 15;
  localparam int SRC = 30;
  localparam int DST = 0;
  localparam int RUN_EDGES = 6 * NW + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [4:0] corr_cnt;
  logic [4:0] dbl_cnt;
  logic       done;
  logic [2:0] dbg_state;

  hamming_secded_decoder #(
    .NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST), .AW(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .corr_cnt(corr_cnt), .dbl_cnt(dbl_cnt), .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory with synchronous read; the bench preloads it through the ld_* port
  logic [7:0] mem [0:255];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = 8'd0;
  logic [7:0] ld_data = 8'd0;
  int         oob_writes = 0;

  always @(posedge clk) begin
    mem_rd_data <= mem[mem_addr];
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      if (int'(mem_addr) >= DST + 2 * NW) oob_writes <= oob_writes + 1;
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [15:0] src_w [NW];
  logic [7:0]  exp_b [2*NW];
  int          exp_corr;
  int          exp_dbl;
  int          data_pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w;
    logic        p;
    w = '0;
    for (int i = 0; i < 11; i++) w[data_pos[i]] = d[i];
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int j = 1; j < 16; j++) if (j[k]) p = p ^ w[j];
      w[1 << k] = p;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    logic [10:0] d;
    for (int i = 0; i < 11; i++) d[i] = w[data_pos[i]];
    return d;
  endfunction

  // Expected output follows from how many flips were injected, not from decoding
  task automatic gen_word(input int i, input int nf);
    logic [10:0] d;
    logic [10:0] dd;
    logic [15:0] w;
    logic [1:0]  f;
    int          b0;
    int          b1;
    d  = 11'($urandom);
    w  = encode(d);
    b0 = int'($urandom_range(0, 15));
    b1 = b0;
    while (b1 == b0) b1 = int'($urandom_range(0, 15));
    if (nf >= 1) w[b0] = ~w[b0];
    if (nf == 2) w[b1] = ~w[b1];
    src_w[i] = w;
    f  = (nf == 0) ? 2'b00 : (nf == 1) ? 2'b01 : 2'b10;
    dd = (nf == 2) ? extract(w) : d;
    exp_b[2*i]   = dd[7:0];
    exp_b[2*i+1] = {f, 3'b000, dd[10:8]};
    if (nf == 1) exp_corr++;
    if (nf == 2) exp_dbl++;
  endtask

  task automatic gen_run(input int mode);
    exp_corr = 0;
    exp_dbl  = 0;
    for (int i = 0; i < NW; i++)
      gen_word(i, (mode < 0) ? int'($urandom_range(0, 2)) : mode);
  endtask

  task automatic load_all();
    for (int i = 0; i < 2 * NW; i++) begin
      @(negedge clk); ld_en = 1'b1; ld_addr = 8'(DST + i); ld_data = 8'hEE;
    end
    for (int i = 0; i < NW; i++) begin
      @(negedge clk); ld_en = 1'b1; ld_addr = 8'(SRC + 2*i);     ld_data = src_w[i][7:0];
      @(negedge clk); ld_en = 1'b1; ld_addr = 8'(SRC + 2*i + 1); ld_data = src_w[i][15:8];
    end
    @(negedge clk); ld_en = 1'b0;
  endtask

  task automatic run_wait(output int edges);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    edges = 0;
    while (done !== 1'b1 && edges < 300) begin
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", mem_addr); end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", mem_wr_en); end
    checks++; if (mem_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h exp 00", mem_wr_data); end
    checks++; if (corr_cnt !== 5'd0) begin errors++; $display("FAIL reset_corr got %0d exp 0", corr_cnt); end
    checks++; if (dbl_cnt !== 5'd0) begin errors++; $display("FAIL reset_dbl got %0d exp 0", dbl_cnt); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] tw [4] = '{16'hAA5A, 16'hAA1A, 16'hAA5B, 16'hA81A};
    logic [7:0]  th [4] = '{8'h05, 8'h45, 8'h45, 8'h85};
    logic [7:0]  tl [4] = '{8'h55, 8'h55, 8'h55, 8'h41};
    int          tc [4] = '{0, 1, 1, 0};
    int          td [4] = '{0, 0, 0, 1};
    int          edges;
    for (int t = 0; t < 4; t++) begin
      gen_run(0);
      src_w[0] = tw[t];
      load_all();
      run_wait(edges);
      checks++; if (edges != RUN_EDGES) begin errors++; $display("FAIL dir%0d_edges got %0d exp %0d", t, edges, RUN_EDGES); end
      checks++; if (mem[DST+1] !== th[t]) begin errors++; $display("FAIL dir%0d_hi got %h exp %h", t, mem[DST+1], th[t]); end
      checks++; if (mem[DST] !== tl[t]) begin errors++; $display("FAIL dir%0d_lo got %h exp %h", t, mem[DST], tl[t]); end
      checks++; if (int'(corr_cnt) != tc[t]) begin errors++; $display("FAIL dir%0d_corr got %0d exp %0d", t, corr_cnt, tc[t]); end
      checks++; if (int'(dbl_cnt) != td[t]) begin errors++; $display("FAIL dir%0d_dbl got %0d exp %0d", t, dbl_cnt, td[t]); end
      for (int i = 2; i < 2 * NW; i++) begin
        checks++;
        if (mem[DST+i] !== exp_b[i]) begin errors++; $display("FAIL dir%0d_byte%0d got %h exp %h", t, i, mem[DST+i], exp_b[i]); end
      end
    end
  endtask

  task automatic test_full_random();
    int edges;
    int oob0;
    oob0 = oob_writes;
    gen_run(-1);
    load_all();
    run_wait(edges);
    checks++; if (edges != RUN_EDGES) begin errors++; $display("FAIL rnd_edges got %0d exp %0d", edges, RUN_EDGES); end
    for (int i = 0; i < 2 * NW; i++) begin
      checks++;
      if (mem[DST+i] !== exp_b[i]) begin errors++; $display("FAIL rnd_byte%0d got %h exp %h", i, mem[DST+i], exp_b[i]); end
    end
    checks++; if (int'(corr_cnt) != exp_corr) begin errors++; $display("FAIL rnd_corr got %0d exp %0d", corr_cnt, exp_corr); end
    checks++; if (int'(dbl_cnt) != exp_dbl) begin errors++; $display("FAIL rnd_dbl got %0d exp %0d", dbl_cnt, exp_dbl); end
    checks++; if (oob_writes != oob0) begin errors++; $display("FAIL rnd_oob got %0d exp %0d", oob_writes - oob0, 0); end
  endtask

  task automatic test_busy_start();
    int edges;
    gen_run(-1);
    load_all();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    edges = 0;
    while (done !== 1'b1 && edges < 300) begin
      if (edges == 40) start = 1'b1;
      else start = 1'b0;
      @(posedge clk); #1; edges++;
    end
    start = 1'b0;
    checks++; if (edges != RUN_EDGES) begin errors++; $display("FAIL busy_edges got %0d exp %0d", edges, RUN_EDGES); end
    for (int i = 0; i < 2 * NW; i++) begin
      checks++;
      if (mem[DST+i] !== exp_b[i]) begin errors++; $display("FAIL busy_byte%0d got %h exp %h", i, mem[DST+i], exp_b[i]); end
    end
    checks++; if (int'(corr_cnt) != exp_corr) begin errors++; $display("FAIL busy_corr got %0d exp %0d", corr_cnt, exp_corr); end
    checks++; if (int'(dbl_cnt) != exp_dbl) begin errors++; $display("FAIL busy_dbl got %0d exp %0d", dbl_cnt, exp_dbl); end
  endtask

  task automatic test_restart_from_done();
    int edges;
    for (int m = 1; m >= 0; m--) begin
      for (int pass = 0; pass < 2; pass++) begin
        gen_run(pass == 0 ? 2 * m : m);
        load_all();
        run_wait(edges);
        checks++; if (edges != RUN_EDGES) begin errors++; $display("FAIL rst%0d%0d_edges got %0d exp %0d", m, pass, edges, RUN_EDGES); end
        checks++; if (int'(corr_cnt) != exp_corr) begin errors++; $display("FAIL rst%0d%0d_corr got %0d exp %0d", m, pass, corr_cnt, exp_corr); end
        checks++; if (int'(dbl_cnt) != exp_dbl) begin errors++; $display("FAIL rst%0d%0d_dbl got %0d exp %0d", m, pass, dbl_cnt, exp_dbl); end
        for (int i = 0; i < 2 * NW; i++) begin
          checks++;
          if (mem[DST+i] !== exp_b[i]) begin errors++; $display("FAIL rst%0d%0d_byte%0d got %h exp %h", m, pass, i, mem[DST+i], exp_b[i]); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int edges;
    gen_run(-1);
    load_all();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #1; reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done%0d got %b exp 0", c, done); end
      checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr%0d got %b exp 0", c, mem_wr_en); end
      checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL midrst_state%0d got %0d exp 0", c, dbg_state); end
    end
    reset = 1'b1;
    gen_run(-1);
    load_all();
    run_wait(edges);
    checks++; if (edges != RUN_EDGES) begin errors++; $display("FAIL after_rst_edges got %0d exp %0d", edges, RUN_EDGES); end
    checks++; if (int'(corr_cnt) != exp_corr) begin errors++; $display("FAIL after_rst_corr got %0d exp %0d", corr_cnt, exp_corr); end
    checks++; if (int'(dbl_cnt) != exp_dbl) begin errors++; $display("FAIL after_rst_dbl got %0d exp %0d", dbl_cnt, exp_dbl); end
    for (int i = 0; i < 2 * NW; i++) begin
      checks++;
      if (mem[DST+i] !== exp_b[i]) begin errors++; $display("FAIL after_rst_byte%0d got %h exp %h", i, mem[DST+i], exp_b[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_full_random();
    test_busy_start();
    test_restart_from_done();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
